// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
//   Bit-serial add/subtract unit. One 1-bit full-adder cell is reused over
//   WIDTH clock cycles, starting at the LSB. Subtraction is computed as
//   A + ~B + 1: B is stored inverted and the carry is seeded with 1.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of any operation in progress
//   in_valid   operands present          in_ready   can accept (IDLE only)
//   a, b       operands                  op_sub     0: A+B, 1: A-B
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   res        result modulo 2^WIDTH
//   flag       add: carry out, sub: borrow (1 when A < B unsigned)
//   ovf        signed two's-complement overflow
//   busy       high in RUN or DONE
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             flag,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;

  // Operand holding registers; only written on accept, so they need no reset.
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q;
  logic             load;

  logic abit, bbit, sum, cout;

  // The shared full-adder cell.
  assign abit = a_q[cnt_q];
  assign bbit = b_q[cnt_q];
  assign sum  = abit ^ bbit ^ carry_q;
  assign cout = (abit & bbit) | (bbit & carry_q) | (abit & carry_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    if (clear) begin
      // Abort wins over both handshakes.
      state_d = S_IDLE;
      cnt_d   = '0;
      carry_d = 1'b0;
      res_d   = '0;
      flag_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            load    = 1'b1;
            carry_d = op_sub;  // the +1 of A + ~B + 1
            cnt_d   = '0;
            res_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          res_d[cnt_q] = sum;
          carry_d      = cout;
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            flag_d  = sub_q ? ~cout : cout;
            // carry_q here is the carry into the MSB.
            ovf_d   = carry_q ^ cout;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_q   <= a;
      b_q   <= op_sub ? ~b : b;
      sub_q <= op_sub;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign flag      = flag_q;
  assign ovf       = ovf_q;

endmodule
